apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one APB master (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16: cycles to wait for transfer completion before aborting (timeout build only).
REQ-003 SHALL have port Pclk, input, 1: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port Preset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester request, held until accepted.
REQ-006 SHALL have port req_write, input, NREQ: per-requester direction, 1 = write.
REQ-007 SHALL have port req_addr, input, NREQ*32: packed addresses; requester i uses bits [32i+31:32i].
REQ-008 SHALL have port req_wdata, input, NREQ*32: packed write data, same packing.
REQ-009 SHALL have port req_ready, output, NREQ: one-hot acceptance pulse.
REQ-010 SHALL have port resp_valid, output, NREQ: one-hot completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: read data, valid with resp_valid.
REQ-012 SHALL have port resp_err, output, 1: timeout abort flag, valid with resp_valid.
REQ-013 SHALL have port transfer, output, 1: transfer request to the APB master.
REQ-014 SHALL have port addr_temp, output, 33: {write, address} to the APB master.
REQ-015 SHALL have port data_temp, output, 32: write data to the APB master.
REQ-016 SHALL have port Psel, input, 1: APB select, observed from the APB master.
REQ-017 SHALL have port Penable, input, 1: APB enable, observed from the APB master.
REQ-018 SHALL have port Pready, input, 1: slave ready.
REQ-019 SHALL have port rdata_temp, input, 32: read data returned by the APB master.

Function
REQ-020 SHALL implement FSM IDLE -> XFER -> RESP -> IDLE.
REQ-021 In IDLE with any req_valid set, SHALL grant round-robin: search starts at index ptr+1 mod NREQ; first set bit wins.
REQ-022 On the granting edge, SHALL latch winner's write/addr/wdata, pulse req_ready[winner] for exactly that cycle, and enter XFER.
REQ-023 In XFER, SHALL drive transfer=1, addr_temp={write,addr}, data_temp=wdata, all registered and stable for the whole state.
REQ-024 Completion SHALL be Psel & Penable & Pready sampled on a rising edge; on that edge SHALL capture rdata_temp (reads) or 0 (writes) into resp_rdata and enter RESP.
REQ-025 In RESP, SHALL drive transfer=0, pulse resp_valid[grant] for one cycle, and set ptr=grant; the next grant occurs no earlier than the following IDLE cycle.
REQ-026 Pready low in XFER SHALL hold XFER indefinitely (non-timeout build) with outputs unchanged.
REQ-027 req_valid changes of non-granted requesters during XFER/RESP SHALL not affect the current transfer.
REQ-028 At most one bit of req_ready and of resp_valid SHALL be set in any cycle.

Reset
REQ-029 Preset high SHALL immediately force: state IDLE, transfer=0, addr_temp=0, data_temp=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, ptr=NREQ-1 (requester 0 first).
REQ-030 Reset mid-XFER SHALL abandon the transfer silently (no resp_valid).

Configuration
REQ-031 With APB_ARB_TIMEOUT_EN defined, SHALL count XFER cycles; if TIMEOUT_CYC cycles elapse without completion, SHALL enter RESP with resp_err=1, resp_rdata=0.
REQ-032 Without APB_ARB_TIMEOUT_EN, SHALL have no counter and SHALL hold resp_err at 0.

Verification
REQ-033 Write req0 addr 0xA000_0000 data 0xDEADBEEF, Pready=1 -> addr_temp=0x1_A000_0000, data_temp=0xDEADBEEF, one resp_valid[0], resp_err=0.
REQ-034 Read req1 addr 0xA000_0004, rdata_temp=0x12345678 -> addr_temp=0x0_A000_0004, resp_rdata=0x12345678 with resp_valid[1].
REQ-035 All four req_valid held from reset release -> grant order 0,1,2,3,0; no double grants.
REQ-036 Pready low for 3 cycles of access -> transfer stays 1, no resp_valid until Pready=1.
REQ-037 APB_ARB_TIMEOUT_EN defined, Pready stuck 0 -> resp_valid after 16 XFER cycles, resp_err=1, resp_rdata=0, transfer dropped.
REQ-038 Preset asserted mid-XFER -> transfer=0 without waiting for a clock edge, no resp_valid; after release, requester 0 wins first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one APB master (IDLE -> XFER -> RESP).
// Optional build macro APB_ARB_TIMEOUT_EN adds an XFER watchdog that aborts with resp_err=1.
module apb_req_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              transfer,
  output logic [32:0]       addr_temp,
  output logic [31:0]       data_temp,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pready,
  input  logic [31:0]       rdata_temp
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("apb_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic            transfer_q;
  logic [32:0]     addr_q;
  logic [31:0]     data_q;
  logic [NREQ-1:0] ready_q;
  logic [NREQ-1:0] rvalid_q;
  logic [31:0]     rdata_q;

  logic [31:0]     addr_a  [NREQ];
  logic [31:0]     wdata_a [NREQ];
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            done;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*32 +: 32];
    assign wdata_a[g] = req_wdata[g*32 +: 32];
  end

  assign done = Psel & Penable & Pready;

  // Rotating priority: scan from ptr+1 upward, wrapping, first set request wins.
  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(ptr_q) + k) % NREQ;
      cand_idx = cand[IW-1:0];
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state_q    <= S_IDLE;
      ptr_q      <= IW'(NREQ - 1);
      grant_q    <= '0;
      transfer_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ready_q  <= '0;
      rvalid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q    <= win_idx;
            ready_q    <= NREQ'(1) << win_idx;
            addr_q     <= {req_write[win_idx], addr_a[win_idx]};
            data_q     <= wdata_a[win_idx];
            transfer_q <= 1'b1;
            state_q    <= S_XFER;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        S_XFER: begin
          if (done) begin
            rdata_q    <= addr_q[32] ? '0 : rdata_temp;
            transfer_q <= 1'b0;
            rvalid_q   <= NREQ'(1) << grant_q;
            ptr_q      <= grant_q;
            state_q    <= S_RESP;
`ifdef APB_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            // Completion wins over a coincident timeout on the same edge.
            rdata_q    <= '0;
            err_q      <= 1'b1;
            transfer_q <= 1'b0;
            rvalid_q   <= NREQ'(1) << grant_q;
            ptr_q      <= grant_q;
            state_q    <= S_RESP;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
`endif
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign transfer   = transfer_q;
  assign addr_temp  = addr_q;
  assign data_temp  = data_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: APB master model plus a round-robin reference model.
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic              Pclk = 1'b0;
  logic              Preset;
  logic [NREQ-1:0]   req_valid, req_write;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [NREQ-1:0]   req_ready, resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err, transfer;
  logic [32:0]       addr_temp;
  logic [31:0]       data_temp;
  logic              Psel, Penable, Pready;
  logic [31:0]       rdata_temp;

  int errors = 0;
  int checks = 0;
  int m_ptr;
  int ws_cfg = 0;
  logic [31:0] rd_cfg = '0;
  int ws_cnt;

  apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .Pclk(Pclk), .Preset(Preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .transfer(transfer), .addr_temp(addr_temp), .data_temp(data_temp),
    .Psel(Psel), .Penable(Penable), .Pready(Pready), .rdata_temp(rdata_temp)
  );

  always #5 Pclk = ~Pclk;

  // APB master: setup phase, then access phase with ws_cfg wait states.
  initial begin
    Psel = 0; Penable = 0; Pready = 0; rdata_temp = '0; ws_cnt = 0;
    forever begin
      @(posedge Pclk); #1;
      if (Preset || !transfer) begin
        Psel = 0; Penable = 0; Pready = 0;
      end else if (!Psel) begin
        Psel = 1;
      end else if (!Penable) begin
        Penable = 1; ws_cnt = ws_cfg; Pready = (ws_cnt == 0); rdata_temp = rd_cfg;
      end else if (!Pready) begin
        ws_cnt--; if (ws_cnt == 0) Pready = 1;
      end else begin
        Psel = 0; Penable = 0; Pready = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (((mask >> idx) & NREQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (((v >> i) & NREQ'(1)) != '0) r = i;
    return r;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Observes one grant and its response; comparisons are done by the caller.
  task automatic observe_txn(input bit drop, output int g_idx, output int g_cnt,
                             output logic [32:0] at, output logic [31:0] dt,
                             output int r_idx, output int r_cnt, output logic [31:0] rd,
                             output logic err, output int xfer_cyc, output bit stable,
                             output bit stray, output bit got);
    got = 0; g_idx = -1; g_cnt = 0; r_idx = -1; r_cnt = 0; at = '0; dt = '0;
    rd = '0; err = 0; xfer_cyc = 0; stable = 1; stray = 0;
    for (int c = 0; c < 40 && g_idx < 0; c++) begin
      @(negedge Pclk);
      if (resp_valid != '0) stray = 1;
      if (req_ready != '0) begin
        g_idx = onehot_idx(req_ready); g_cnt = $countones(req_ready);
        at = addr_temp; dt = data_temp;
        xfer_cyc = transfer ? 1 : 0;
        if (drop) req_valid = req_valid & ~req_ready;
      end
    end
    if (g_idx < 0) return;
    for (int c = 0; c < 200 && r_idx < 0; c++) begin
      @(negedge Pclk);
      if (req_ready != '0) stray = 1;
      if (resp_valid != '0) begin
        r_idx = onehot_idx(resp_valid); r_cnt = $countones(resp_valid);
        rd = resp_rdata; err = resp_err;
        if (transfer !== 1'b0) stable = 0;
      end else begin
        if (transfer) xfer_cyc++;
        if (transfer !== 1'b1 || addr_temp !== at || data_temp !== dt) stable = 0;
      end
    end
    got = (r_idx >= 0);
  endtask

  task automatic test_reset;
    Preset = 1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge Pclk);
    checks++; if (transfer !== 1'b0) begin errors++; $display("FAIL reset_transfer: got %0b want 0", transfer); end
    checks++; if (addr_temp !== 33'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_temp); end
    checks++; if (data_temp !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_temp); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
    Preset = 0; m_ptr = NREQ - 1;
  endtask

  task automatic test_write;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    set_req(0, 1'b1, 32'hA000_0000, 32'hDEAD_BEEF);
    ws_cfg = 0; rd_cfg = 32'h5A5A_1234;
    exp = model_pick(4'b0001);
    req_valid = 4'b0001;
    observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
    checks++; if (!got) begin errors++; $display("FAIL wr_done: got no response want one"); end
    checks++; if (g != exp || gc != 1) begin errors++; $display("FAIL wr_grant: got %0d(x%0d) want %0d", g, gc, exp); end
    checks++; if (at !== 33'h1_A000_0000) begin errors++; $display("FAIL wr_addr: got %h want 1a0000000", at); end
    checks++; if (dt !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", dt); end
    checks++; if (r != 0 || rc != 1) begin errors++; $display("FAIL wr_resp: got %0d(x%0d) want 0", r, rc); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_result: got err=%b rd=%h want 0/0", err, rd); end
    checks++; if (xc != 2 || !st || sy) begin errors++; $display("FAIL wr_timing: got cyc=%0d stable=%0b stray=%0b want 2/1/0", xc, st, sy); end
    @(negedge Pclk);
    checks++; if (resp_valid !== '0) begin errors++; $display("FAIL wr_single_pulse: got %b want 0", resp_valid); end
    m_ptr = exp;
  endtask

  task automatic test_read;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    set_req(1, 1'b0, 32'hA000_0004, $urandom);
    ws_cfg = 0; rd_cfg = 32'h1234_5678;
    exp = model_pick(4'b0010);
    req_valid = 4'b0010;
    observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
    checks++; if (!got || g != exp) begin errors++; $display("FAIL rd_grant: got %0d done=%0b want %0d", g, got, exp); end
    checks++; if (at !== 33'h0_A000_0004) begin errors++; $display("FAIL rd_addr: got %h want 0a0000004", at); end
    checks++; if (r != 1 || rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got idx=%0d rd=%h want 1/12345678", r, rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
    m_ptr = exp;
  endtask

  task automatic test_wait_states;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    logic [31:0] a, d;
    a = $urandom; d = $urandom;
    set_req(2, 1'b1, a, d);
    ws_cfg = 3; rd_cfg = $urandom;
    exp = model_pick(4'b0100);
    req_valid = 4'b0100;
    observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
    checks++; if (!got || g != exp || r != exp) begin errors++; $display("FAIL ws_idx: got g=%0d r=%0d want %0d", g, r, exp); end
    checks++; if (xc != 5) begin errors++; $display("FAIL ws_cycles: got %0d want 5", xc); end
    checks++; if (!st || sy) begin errors++; $display("FAIL ws_stable: got stable=%0b stray=%0b want 1/0", st, sy); end
    checks++; if (at !== {1'b1, a} || dt !== d) begin errors++; $display("FAIL ws_addr: got %h/%h want %h/%h", at, dt, {1'b1, a}, d); end
    ws_cfg = 0; m_ptr = exp;
  endtask

  task automatic test_round_robin;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    logic [31:0] a [NREQ];
    @(negedge Pclk); Preset = 1;
    for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; set_req(i, 1'b0, a[i], $urandom); end
    req_valid = '1; ws_cfg = 0;
    @(negedge Pclk); Preset = 0; m_ptr = NREQ - 1;
    for (int n = 0; n < 5; n++) begin
      exp = model_pick('1);
      rd_cfg = $urandom;
      observe_txn(0, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
      checks++;
      if (!got || g != exp || gc != 1 || r != exp || rc != 1 || sy)
        begin errors++; $display("FAIL rr_order[%0d]: got g=%0d x%0d r=%0d x%0d want %0d", n, g, gc, r, rc, exp); end
      checks++; if (exp >= 0 && (at !== {1'b0, a[exp]} || rd !== rd_cfg))
        begin errors++; $display("FAIL rr_payload[%0d]: got %h/%h want %h/%h", n, at, rd, {1'b0, a[exp]}, rd_cfg); end
      m_ptr = exp;
    end
    req_valid = '0;
  endtask

  task automatic test_random;
    int g, gc, r, rc, xc, exp, ws; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    logic [NREQ-1:0] mask; logic [31:0] a [NREQ]; logic [31:0] d [NREQ]; logic w [NREQ];
    for (int round = 0; round < 8; round++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        a[i] = $urandom; d[i] = $urandom; w[i] = 1'($urandom_range(0, 1));
        set_req(i, w[i], a[i], d[i]);
      end
      req_valid = mask;
      while (mask != '0) begin
        exp = model_pick(mask);
        ws = $urandom_range(0, 3); ws_cfg = ws; rd_cfg = $urandom;
        observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
        checks++;
        if (!got || g != exp || gc != 1 || r != exp || rc != 1)
          begin errors++; $display("FAIL rnd_idx: got g=%0d r=%0d want %0d", g, r, exp); end
        if (exp < 0) break;
        checks++; if (at !== {w[exp], a[exp]} || dt !== d[exp])
          begin errors++; $display("FAIL rnd_req: got %h/%h want %h/%h", at, dt, {w[exp], a[exp]}, d[exp]); end
        checks++; if (rd !== (w[exp] ? 32'h0 : rd_cfg) || err !== 1'b0)
          begin errors++; $display("FAIL rnd_resp: got %h err=%b want %h err=0", rd, err, (w[exp] ? 32'h0 : rd_cfg)); end
        checks++; if (xc != 2 + ws || !st || sy)
          begin errors++; $display("FAIL rnd_timing: got cyc=%0d stable=%0b stray=%0b want %0d/1/0", xc, st, sy, 2 + ws); end
        mask = mask & ~(NREQ'(1) << exp);
        m_ptr = exp;
      end
    end
    ws_cfg = 0;
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    set_req(3, 1'b0, $urandom, $urandom);
    ws_cfg = 1000000; rd_cfg = 32'hFFFF_FFFF;
    exp = model_pick(4'b1000);
    req_valid = 4'b1000;
    observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
    checks++; if (!got || r != exp) begin errors++; $display("FAIL to_resp: got %0d done=%0b want %0d", r, got, exp); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL to_result: got err=%b rd=%h want 1/0", err, rd); end
    checks++; if (xc != TO || !st) begin errors++; $display("FAIL to_cycles: got %0d stable=%0b want %0d/1", xc, st, TO); end
    ws_cfg = 0; m_ptr = exp;
    @(negedge Pclk);
  endtask
`endif

  task automatic test_reset_mid_xfer;
    int g, gc, r, rc, xc, exp; logic [32:0] at; logic [31:0] dt, rd; logic err; bit st, sy, got;
    bit seen;
    seen = 0;
    set_req(2, 1'b1, $urandom, $urandom);
    set_req(0, 1'b0, $urandom, $urandom);
    ws_cfg = 1000000;
    req_valid = 4'b0100;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Pclk);
      if (req_ready != '0) begin seen = 1; req_valid = '0; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_grant: got no grant want one"); end
    repeat (3) @(negedge Pclk);
    checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL rst_pre_xfer: got %b want 1", transfer); end
    Preset = 1; #1;
    checks++; if (transfer !== 1'b0 || addr_temp !== 33'h0 || data_temp !== 32'h0)
      begin errors++; $display("FAIL rst_async: got %b/%h/%h want 0/0/0", transfer, addr_temp, data_temp); end
    req_valid = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      @(negedge Pclk);
      checks++; if (resp_valid !== '0 || req_ready !== '0)
        begin errors++; $display("FAIL rst_silent: got rv=%b rr=%b want 0/0", resp_valid, req_ready); end
    end
    Preset = 0; m_ptr = NREQ - 1; ws_cfg = 0;
    for (int n = 0; n < 2; n++) begin
      exp = model_pick(req_valid);
      observe_txn(1, g, gc, at, dt, r, rc, rd, err, xc, st, sy, got);
      checks++; if (!got || g != exp || r != exp || sy)
        begin errors++; $display("FAIL rst_after[%0d]: got g=%0d r=%0d want %0d", n, g, r, exp); end
      m_ptr = exp;
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wait_states;
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_round_robin;
    test_random;
    test_reset_mid_xfer;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
